// File: rtl/holy_cache_multiline_if.sv
// Core cache-state encoding and the AXI4 bus bundle between the cache and the external fabric.
// Response IDs are omitted because the cache only ever issues ID 0 with one transaction in flight.
package holy_core_pkg;
   typedef enum logic [2:0] {
      IDLE,
      SENDING_WRITE_REQ,
      SENDING_WRITE_DATA,
      WAITING_WRITE_RES,
      SENDING_READ_REQ,
      RECEIVING_READ_DATA
   } cache_state_t;
endpackage

interface axi_if;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input wdata, wstrb, wlast, wvalid, output wready,
      output bresp, bvalid, input bready,
      input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/holy_cache_multiline.sv
// Direct-mapped write-back/write-allocate cache, one AXI INCR burst per line fill or eviction.
// Latency: hits return data combinationally; a miss stalls for the write-back (if dirty) plus the fill.
// Backpressure: every AXI beat waits on its ready/valid; HOLY_CACHE_PERF_COUNTERS_EN adds hit/miss counters.
module holy_cache_multiline
   import holy_core_pkg::*;
#(
   parameter int NUM_LINES      = 8,
   parameter int WORDS_PER_LINE = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  address,
   input  logic [31:0]  write_data,
   input  logic         read_enable,
   input  logic         write_enable,
   input  logic [3:0]   byte_enable,
   output logic [31:0]  read_data,
   output logic         cache_stall,
   output logic         bus_error,
   output cache_state_t cache_state,
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count,
`endif
   axi_if.master        axi
);
   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   cache_state_t     state;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic [OFF_W-1:0] beat_ptr;
   logic             unused_addr;

   logic [31:0]      data [NUM_LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0] tags [NUM_LINES];
   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;

   logic hit, access, in_idle, wr_hit, fill_err;
   logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

   assign req_tag     = address[31 -: TAG_W];
   assign idx         = address[2+OFF_W +: IDX_W];
   assign off         = address[2 +: OFF_W];
   assign unused_addr = ^address[1:0];

   assign hit         = valid[idx] && (tags[idx] == req_tag);
   assign access      = read_enable ^ write_enable;
   assign in_idle     = (state == IDLE);
   assign wr_hit      = in_idle && write_enable && !read_enable && hit;
   assign cache_stall = !in_idle || (access && !hit);
   assign read_data   = (in_idle && read_enable && !write_enable && hit) ? data[idx][off] : 32'h0;
   assign cache_state = state;

   assign axi.awid    = 4'h0;
   assign axi.awaddr  = {tags[idx], idx, {OFF_W{1'b0}}, 2'b00};
   assign axi.awlen   = 8'(WORDS_PER_LINE - 1);
   assign axi.awsize  = 3'b010;
   assign axi.awburst = 2'b01;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = data[idx][beat_ptr];
   assign axi.wstrb   = 4'hF;
   assign axi.wlast   = wvalid_q && (beat_ptr == LAST_BEAT);
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.arid    = 4'h0;
   assign axi.araddr  = {req_tag, idx, {OFF_W{1'b0}}, 2'b00};
   assign axi.arlen   = 8'(WORDS_PER_LINE - 1);
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   // Data array has no reset; a fill abandoned by reset leaves the line invalid anyway.
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_enable[b]) data[idx][off][8*b +: 8] <= write_data[8*b +: 8];
         end
      end else if (state == RECEIVING_READ_DATA && rready_q && axi.rvalid) begin
         data[idx][beat_ptr] <= axi.rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         valid     <= '0;
         dirty     <= '0;
         for (int i = 0; i < NUM_LINES; i++) tags[i] <= '0;
         beat_ptr  <= '0;
         bus_error <= 1'b0;
         fill_err  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (access && !hit) begin
                  if (dirty[idx]) begin
                     state     <= SENDING_WRITE_REQ;
                     awvalid_q <= 1'b1;
                  end else begin
                     state     <= SENDING_READ_REQ;
                     arvalid_q <= 1'b1;
                  end
               end else if (wr_hit) begin
                  dirty[idx] <= 1'b1;
               end
            end
            SENDING_WRITE_REQ: begin
               if (axi.awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  beat_ptr  <= '0;
                  state     <= SENDING_WRITE_DATA;
               end
            end
            SENDING_WRITE_DATA: begin
               if (axi.wready) begin
                  beat_ptr <= beat_ptr + 1'b1;
                  if (beat_ptr == LAST_BEAT) begin
                     wvalid_q <= 1'b0;
                     bready_q <= 1'b1;
                     state    <= WAITING_WRITE_RES;
                  end
               end
            end
            WAITING_WRITE_RES: begin
               if (axi.bvalid) begin
                  dirty[idx] <= 1'b0;
                  if (axi.bresp != 2'b00) bus_error <= 1'b1;
                  bready_q  <= 1'b0;
                  arvalid_q <= 1'b1;
                  state     <= SENDING_READ_REQ;
               end
            end
            SENDING_READ_REQ: begin
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  beat_ptr  <= '0;
                  fill_err  <= 1'b0;
                  state     <= RECEIVING_READ_DATA;
               end
            end
            RECEIVING_READ_DATA: begin
               if (axi.rvalid) begin
                  beat_ptr <= beat_ptr + 1'b1;
                  if (axi.rresp != 2'b00) fill_err <= 1'b1;
                  // An early rlast still closes the fill; unreceived words stay stale.
                  if (axi.rlast) begin
                     rready_q <= 1'b0;
                     state    <= IDLE;
                     if (fill_err || axi.rresp != 2'b00) begin
                        valid[idx] <= 1'b0;
                        bus_error  <= 1'b1;
                     end else begin
                        tags[idx]  <= req_tag;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state     <= IDLE;
               awvalid_q <= 1'b0;
               wvalid_q  <= 1'b0;
               bready_q  <= 1'b0;
               arvalid_q <= 1'b0;
               rready_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef HOLY_CACHE_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         if (in_idle && access && hit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'h1;
         if (in_idle && access && !hit && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'h1;
      end
   end
`endif

   always @(posedge clk) begin
      if (rst_n && read_enable && write_enable)
         $error("holy_cache_multiline: read_enable and write_enable asserted together");
   end
endmodule

// File: tb/tb_holy_cache_multiline.sv
// Directed bench for holy_cache_multiline with a behavioural AXI slave and sparse memory model.
module tb_holy_cache_multiline;
   import holy_core_pkg::*;
   localparam int WPL = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [31:0]  address, write_data, read_data;
   logic         read_enable, write_enable, cache_stall, bus_error;
   logic [3:0]   byte_enable;
   cache_state_t cache_state;
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
   logic [31:0]  hit_count, miss_count;
`endif

   axi_if axi_bus();

   holy_cache_multiline #(.NUM_LINES(8), .WORDS_PER_LINE(WPL)) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
      .read_enable(read_enable), .write_enable(write_enable), .byte_enable(byte_enable),
      .read_data(read_data), .cache_stall(cache_stall), .bus_error(bus_error),
      .cache_state(cache_state),
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .axi(axi_bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Slave model state and observations
   logic [31:0] mem [bit [31:0]];
   bit          rand_mode = 1'b0;
   logic [1:0]  bresp_knob = 2'b00;
   int          rlast_beat = WPL - 1;
   bit          r_active, w_active, b_pending, holding;
   int          r_beat, w_beat;
   bit [31:0]   ar_base, aw_base;
   int          ar_count = 0, aw_count = 0, r_hs = 0, w_hs = 0;
   int          wlast_err = 0, wstrb_err = 0, unstable_err = 0, wover_err = 0;
   logic [31:0] last_araddr, last_awaddr, held;
   logic [7:0]  last_arlen, last_awlen;
   logic [4:0]  last_ar_sizeburst;
   logic [31:0] wlog [WPL];

   function automatic logic [31:0] mem_rd(input bit [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic slave_clear();
      r_active = 1'b0; w_active = 1'b0; b_pending = 1'b0; holding = 1'b0;
      axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
      axi_bus.bresp = 2'b00; axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0;
      axi_bus.rdata = 32'h0; axi_bus.rresp = 2'b00; axi_bus.rlast = 1'b0;
   endtask

   initial begin
      slave_clear();
      forever begin
         @(negedge clk);
         if (!rst_n) slave_clear();
         else begin
            axi_bus.arready = !r_active;
            axi_bus.awready = !w_active && !b_pending;
            axi_bus.wready  = w_active && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
            axi_bus.bvalid  = b_pending;
            axi_bus.bresp   = b_pending ? bresp_knob : 2'b00;
            if (r_active) begin
               axi_bus.rvalid = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
               axi_bus.rdata  = mem_rd(ar_base + 32'(r_beat * 4));
               axi_bus.rresp  = 2'b00;
               axi_bus.rlast  = (r_beat == rlast_beat);
            end else begin
               axi_bus.rvalid = 1'b0;
               axi_bus.rdata  = 32'h0;
               axi_bus.rlast  = 1'b0;
            end
         end
         #1;
         if (!rst_n) slave_clear();
         else begin
            if (axi_bus.rvalid && axi_bus.rready) begin
               r_hs++;
               r_beat++;
               if (axi_bus.rlast) r_active = 1'b0;
            end
            if (axi_bus.arvalid && axi_bus.arready) begin
               ar_count++;
               last_araddr = axi_bus.araddr;
               last_arlen  = axi_bus.arlen;
               last_ar_sizeburst = {axi_bus.arsize, axi_bus.arburst};
               ar_base  = axi_bus.araddr;
               r_active = 1'b1;
               r_beat   = 0;
            end
            if (axi_bus.awvalid && axi_bus.awready) begin
               aw_count++;
               last_awaddr = axi_bus.awaddr;
               last_awlen  = axi_bus.awlen;
               aw_base  = axi_bus.awaddr;
               w_active = 1'b1;
               w_beat   = 0;
               holding  = 1'b0;
            end
            if (axi_bus.wvalid) begin
               if (holding && axi_bus.wdata !== held) unstable_err++;
               if (axi_bus.wready) begin
                  if (w_beat >= WPL) wover_err++;
                  else begin
                     wlog[w_beat] = axi_bus.wdata;
                     mem[aw_base + 32'(w_beat * 4)] = axi_bus.wdata;
                     if (axi_bus.wlast !== (w_beat == WPL - 1)) wlast_err++;
                  end
                  if (axi_bus.wstrb !== 4'hF) wstrb_err++;
                  w_hs++;
                  w_beat++;
                  holding = 1'b0;
                  if (axi_bus.wlast) begin
                     w_active  = 1'b0;
                     b_pending = 1'b1;
                  end
               end else begin
                  holding = 1'b1;
                  held    = axi_bus.wdata;
               end
            end
            if (axi_bus.bvalid && axi_bus.bready) b_pending = 1'b0;
         end
      end
   end

   task automatic wait_unstall(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk); #2;
         if (!cache_stall) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk); #2;
      n_checks++;
      if (cache_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", cache_state, IDLE); end
      n_checks++;
      if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready} !== 5'b0) begin
         n_fail++; $display("FAIL reset_axi: got %b expected 00000",
            {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready});
      end
      n_checks++;
      if ({cache_stall, bus_error, read_data} !== 34'h0) begin
         n_fail++; $display("FAIL reset_outputs: stall=%b err=%b rdata=%h expected 0/0/0", cache_stall, bus_error, read_data);
      end
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
      n_checks++;
      if ({hit_count, miss_count} !== 64'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_count, miss_count); end
`endif
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_cold_read();
      bit ok;
      @(negedge clk); address = 32'h40; read_enable = 1'b1; #2;
      n_checks++;
      if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL cold_stall: got %b expected 1", cache_stall); end
      wait_unstall(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL cold_timeout: stall stuck, expected release"); end
      n_checks++;
      if (ar_count !== 1 || last_araddr !== 32'h40) begin n_fail++; $display("FAIL cold_araddr: got %0d/%h expected 1/00000040", ar_count, last_araddr); end
      n_checks++;
      if (last_arlen !== 8'd15 || last_ar_sizeburst !== 5'b010_01) begin n_fail++; $display("FAIL cold_arlen: got %0d/%b expected 15/01001", last_arlen, last_ar_sizeburst); end
      n_checks++;
      if (r_hs !== 16 || aw_count !== 0) begin n_fail++; $display("FAIL cold_beats: got r=%0d aw=%0d expected 16/0", r_hs, aw_count); end
      n_checks++;
      if (read_data !== 32'h1122_3344) begin n_fail++; $display("FAIL cold_rdata: got %h expected 11223344", read_data); end
      @(negedge clk); address = 32'h7C; #2;
      n_checks++;
      if (cache_stall !== 1'b0 || read_data !== 32'hC0DE_007C) begin n_fail++; $display("FAIL cold_hit_last: got %b/%h expected 0/c0de007c", cache_stall, read_data); end
   endtask

   task automatic test_write_hit();
      @(negedge clk); address = 32'h40; read_enable = 1'b0; write_enable = 1'b1;
      write_data = 32'hDEAD_BEEF; byte_enable = 4'b0011; #2;
      n_checks++;
      if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL wr_hit_stall: got %b expected 0", cache_stall); end
      @(negedge clk); write_enable = 1'b0; read_enable = 1'b1; #2;
      n_checks++;
      if (read_data !== 32'h1122_BEEF) begin n_fail++; $display("FAIL wr_hit_merge: got %h expected 1122beef", read_data); end
      n_checks++;
      if (ar_count !== 1 || aw_count !== 0) begin n_fail++; $display("FAIL wr_hit_bus: got ar=%0d aw=%0d expected 1/0", ar_count, aw_count); end
   endtask

   task automatic test_evict();
      bit ok;
      @(negedge clk); address = 32'h440; #2;
      n_checks++;
      if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL evict_stall: got %b expected 1", cache_stall); end
      wait_unstall(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL evict_timeout: stall stuck, expected release"); end
      n_checks++;
      if (aw_count !== 1 || last_awaddr !== 32'h40 || last_awlen !== 8'd15) begin
         n_fail++; $display("FAIL evict_aw: got %0d/%h/%0d expected 1/00000040/15", aw_count, last_awaddr, last_awlen);
      end
      n_checks++;
      if (w_hs !== 16 || wlast_err !== 0 || wstrb_err !== 0) begin
         n_fail++; $display("FAIL evict_wbeats: got beats=%0d wlast_err=%0d wstrb_err=%0d expected 16/0/0", w_hs, wlast_err, wstrb_err);
      end
      n_checks++;
      if (wlog[0] !== 32'h1122_BEEF || wlog[1] !== 32'hC0DE_0044 || wlog[15] !== 32'hC0DE_007C) begin
         n_fail++; $display("FAIL evict_wdata: got %h/%h/%h expected 1122beef/c0de0044/c0de007c", wlog[0], wlog[1], wlog[15]);
      end
      n_checks++;
      if (ar_count !== 2 || last_araddr !== 32'h440) begin n_fail++; $display("FAIL evict_ar: got %0d/%h expected 2/00000440", ar_count, last_araddr); end
      n_checks++;
      if (read_data !== 32'hC0DE_0440 || bus_error !== 1'b0) begin n_fail++; $display("FAIL evict_rdata: got %h/%b expected c0de0440/0", read_data, bus_error); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int w0;
      logic [31:0] exp;
      rand_mode = 1'b1;
      @(negedge clk); address = 32'h44C; read_enable = 1'b0; write_enable = 1'b1;
      write_data = 32'h0BAD_F00D; byte_enable = 4'hF; #2;
      n_checks++;
      if (cache_stall !== 1'b0) begin n_fail++; $display("FAIL bp_wr_stall: got %b expected 0", cache_stall); end
      w0 = w_hs;
      @(negedge clk); write_enable = 1'b0; read_enable = 1'b1; address = 32'h840;
      wait_unstall(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bp_timeout: stall stuck, expected release"); end
      n_checks++;
      if (w_hs - w0 !== 16 || unstable_err !== 0 || wover_err !== 0 || wlast_err !== 0) begin
         n_fail++; $display("FAIL bp_wchan: got beats=%0d unstable=%0d over=%0d wlast=%0d expected 16/0/0/0",
            w_hs - w0, unstable_err, wover_err, wlast_err);
      end
      for (int i = 0; i < WPL; i++) begin
         exp = (i == 3) ? 32'h0BAD_F00D : 32'hC0DE_0440 + 32'(i * 4);
         n_checks++;
         if (wlog[i] !== exp) begin n_fail++; $display("FAIL bp_wlog[%0d]: got %h expected %h", i, wlog[i], exp); end
      end
      for (int i = 0; i < WPL; i++) begin
         @(negedge clk); address = 32'h840 + 32'(i * 4); #2;
         exp = 32'hC0DE_0840 + 32'(i * 4);
         n_checks++;
         if (cache_stall !== 1'b0 || read_data !== exp) begin
            n_fail++; $display("FAIL bp_fill[%0d]: got %b/%h expected 0/%h", i, cache_stall, read_data, exp);
         end
      end
      rand_mode = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      bit ok;
      int ar0, r0, r_mid;
      ar0 = ar_count; r0 = r_hs;
      @(negedge clk); address = 32'hC40;
      for (int n = 0; n < 200 && (r_hs - r0) < 5; n++) begin @(negedge clk); #2; end
      n_checks++;
      if (r_hs - r0 < 5 || cache_state !== RECEIVING_READ_DATA) begin
         n_fail++; $display("FAIL rst_mid_reach: got beats=%0d state=%0d expected >=5/%0d", r_hs - r0, cache_state, RECEIVING_READ_DATA);
      end
      @(negedge clk); rst_n = 1'b0; #2;
      r_mid = r_hs;
      n_checks++;
      if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready} !== 5'b0 || cache_state !== IDLE) begin
         n_fail++; $display("FAIL rst_mid_axi: got %b state=%0d expected 00000/%0d",
            {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready}, cache_state, IDLE);
      end
      repeat (3) @(negedge clk);
      #2;
      n_checks++;
      if (r_hs !== r_mid || axi_bus.rready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: got beats=%0d rready=%b expected %0d/0", r_hs, axi_bus.rready, r_mid); end
      @(negedge clk); rst_n = 1'b1; #2;
      n_checks++;
      if (cache_stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_miss: got %b expected 1", cache_stall); end
      wait_unstall(ok);
      n_checks++;
      if (!ok || ar_count !== ar0 + 2 || read_data !== 32'hC0DE_0C40) begin
         n_fail++; $display("FAIL rst_mid_refill: got ok=%b ar=%0d rdata=%h expected 1/%0d/c0de0c40", ok, ar_count, read_data, ar0 + 2);
      end
   endtask

   task automatic test_bresp_err();
      bit ok;
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
      logic [31:0] h0, m0;
`endif
      bresp_knob = 2'b10;
      @(negedge clk); address = 32'hC44; read_enable = 1'b0; write_enable = 1'b1;
      write_data = 32'h1234_5678; byte_enable = 4'hF; #2;
      n_checks++;
      if (cache_stall !== 1'b0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL berr_pre: got %b/%b expected 0/0", cache_stall, bus_error); end
      @(negedge clk); write_enable = 1'b0; read_enable = 1'b1; address = 32'h1040;
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
      h0 = hit_count; m0 = miss_count;
`endif
      wait_unstall(ok);
      n_checks++;
      if (!ok || bus_error !== 1'b1) begin n_fail++; $display("FAIL berr_flag: got ok=%b err=%b expected 1/1", ok, bus_error); end
      n_checks++;
      if (last_awaddr !== 32'hC40 || wlog[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL berr_wb: got %h/%h expected 00000c40/12345678", last_awaddr, wlog[1]); end
      n_checks++;
      if (read_data !== 32'hC0DE_1040 || last_araddr !== 32'h1040) begin n_fail++; $display("FAIL berr_fill: got %h/%h expected c0de1040/00001040", read_data, last_araddr); end
`ifdef HOLY_CACHE_PERF_COUNTERS_EN
      n_checks++;
      if (miss_count - m0 !== 32'd1 || hit_count !== h0) begin n_fail++; $display("FAIL berr_counters: got miss+%0d hit=%0d expected 1/%0d", miss_count - m0, hit_count, h0); end
`endif
      bresp_knob = 2'b00;
      @(negedge clk); address = 32'h1044; #2;
      @(negedge clk); #2;
      n_checks++;
      if (bus_error !== 1'b1 || read_data !== 32'hC0DE_1044) begin n_fail++; $display("FAIL berr_sticky: got %b/%h expected 1/c0de1044", bus_error, read_data); end
   endtask

   task automatic test_early_rlast();
      bit ok;
      int r0;
      rlast_beat = 7;
      r0 = r_hs;
      @(negedge clk); address = 32'h80;
      wait_unstall(ok);
      n_checks++;
      if (!ok || r_hs - r0 !== 8) begin n_fail++; $display("FAIL early_beats: got ok=%b beats=%0d expected 1/8", ok, r_hs - r0); end
      n_checks++;
      if (axi_bus.rready !== 1'b0 || cache_state !== IDLE || read_data !== 32'hC0DE_0080) begin
         n_fail++; $display("FAIL early_end: got rready=%b state=%0d rdata=%h expected 0/%0d/c0de0080", axi_bus.rready, cache_state, read_data, IDLE);
      end
      @(negedge clk); address = 32'h9C; #2;
      n_checks++;
      if (cache_stall !== 1'b0 || read_data !== 32'hC0DE_009C) begin n_fail++; $display("FAIL early_word7: got %b/%h expected 0/c0de009c", cache_stall, read_data); end
      rlast_beat = WPL - 1;
      read_enable = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      address = 32'h0; write_data = 32'h0; byte_enable = 4'h0;
      read_enable = 1'b0; write_enable = 1'b0;
      mem[32'h40] = 32'h1122_3344;
      test_reset();
      test_cold_read();
      test_write_hit();
      test_evict();
      test_backpressure();
      test_reset_mid_fill();
      test_bresp_err();
      test_early_rlast();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
